// File: rtl/ca_line_engine.sv
// One-row elementary cellular automaton: holds a CELLS-wide generation, advances it by any
// Wolfram rule on request, and streams it out as pixels (leftmost pixel = MSB cell).
module ca_line_engine #(
    parameter int CELLS    = 64,
    parameter int PIX_LOG2 = 3,
    parameter int GEN_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [7:0]       rule,
    input  logic [1:0]       bmode,
    input  logic             seed_load,
    input  logic             seed_rand,
    input  logic             step,
    input  logic             line_start,
    input  logic             pix_en,
    output logic             cell_out,
    output logic [GEN_W-1:0] gen_count,
    output logic             busy_line
);

    localparam int IW        = $clog2(CELLS);
    localparam int PW        = IW + PIX_LOG2 + 1;
    localparam int PIX_TOTAL = CELLS << PIX_LOG2;
    localparam logic [PW-1:0]    PIX_MAX     = PW'(PIX_TOTAL);
    localparam logic [CELLS-1:0] CENTRE_SEED = {{(CELLS-1){1'b0}}, 1'b1} << (CELLS / 2);

    logic [CELLS-1:0] row;
    logic [CELLS-1:0] row_next;
    logic [CELLS-1:0] rand_row;
    logic [CELLS+1:0] ext;
    logic             edge_hi;
    logic             edge_lo;
    logic [15:0]      lfsr;
    logic             lfsr_fb;
    logic [PW-1:0]    pix_cnt;
    logic [PW-1:0]    pix_cnt_next;
    logic [IW-1:0]    cell_idx;
    logic [IW-1:0]    bit_sel;
    logic             pix_live;

    // Row padded with the boundary neighbours so every cell sees {L,C,R} = ext[i+2:i].
    always_comb begin
        case (bmode)
            2'd1: begin
                edge_hi = 1'b0;
                edge_lo = 1'b0;
            end
            2'd2: begin
                edge_hi = 1'b1;
                edge_lo = 1'b1;
            end
            default: begin
                edge_hi = row[0];
                edge_lo = row[CELLS-1];
            end
        endcase
        ext      = {edge_hi, row, edge_lo};
        row_next = '0;
        for (int i = 0; i < CELLS; i++) begin
            row_next[i] = rule[ext[i +: 3]];
        end
    end

    always_comb begin
        rand_row = '0;
        for (int i = 0; i < CELLS; i++) begin
            rand_row[i] = lfsr[i & 15];
        end
    end

    assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign pix_live = (pix_cnt < PIX_MAX);
    assign cell_idx = pix_cnt[IW+PIX_LOG2-1:PIX_LOG2];
    // CELLS is a power of two, so CELLS-1-idx is just the bitwise complement.
    assign bit_sel  = ~cell_idx;

    always_comb begin
        pix_cnt_next = pix_cnt;
        if (line_start) begin
            pix_cnt_next = '0;
        end else if (pix_en && pix_live) begin
            pix_cnt_next = pix_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row       <= CENTRE_SEED;
            lfsr      <= 16'hACE1;
            pix_cnt   <= '0;
            cell_out  <= 1'b0;
            gen_count <= '0;
            busy_line <= 1'b1;
        end else if (ena) begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
            if (seed_load) begin
                row       <= seed_rand ? rand_row : CENTRE_SEED;
                gen_count <= '0;
            end else if (step) begin
                row       <= row_next;
                gen_count <= gen_count + 1'b1;
            end
            pix_cnt   <= pix_cnt_next;
            cell_out  <= pix_en && pix_live && row[bit_sel];
            busy_line <= (pix_cnt_next < PIX_MAX);
        end
    end

endmodule

// File: doc/ca_line_engine.md
Name: ca_line_engine

Overview:
Parametrised 1D elementary cellular-automaton row engine for the VGA CA top level. It holds one CELLS-wide generation and streams it as pixels during active video. On request it advances one generation using any 8-bit Wolfram rule, with a selectable boundary mode. It is the generalised successor of the fixed-width, fixed-rule CA row logic, and adds runtime rules, boundary modes, LFSR random seeding and a generation counter.

Parameters:
CELLS, 64, cells per row; power of two, 8..256
PIX_LOG2, 3, log2 of pixels per cell; 0..4
GEN_W, 16, generation counter width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; low freezes all state
rule  input  8  Wolfram rule number, sampled at step
bmode  input  2  boundary: 0 wrap, 1 zero-fill, 2 one-fill, 3 treated as 0
seed_load  input  1  pulse: reload row
seed_rand  input  1  with seed_load: 1 = LFSR seed, 0 = single centre cell
step  input  1  pulse: advance one generation
line_start  input  1  pulse: reset pixel position to 0
pix_en  input  1  active-video pixel strobe
cell_out  output  1  registered pixel value
gen_count  output  GEN_W  generations since last seed
busy_line  output  1  high while pixel position < CELLS<<PIX_LOG2

Behaviour:
- Reset (async, rst_n=0):
  - row = only bit CELLS/2 set
  - lfsr = 16'hACE1
  - pix_cnt = 0, cell_out = 0, gen_count = 0, busy_line = 1
- All state updates happen on the rising clk edge and only when ena=1. When ena=0, all registers hold, including the LFSR and outputs.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, x^16+x^14+x^13+x^11+1. Shifts every enabled cycle.
- Next-state rule:
  - next[i] = rule[{L,C,R}], where L=row[i+1], C=row[i], R=row[i-1].
  - Out-of-range neighbours come from bmode: wrap uses the opposite end; zero-fill uses 0; one-fill uses 1.
  - The whole row is computed in a single cycle.
- Row update priority, evaluated per cycle:
  1. seed_load: row = centre seed, or the current lfsr value replicated CELLS/16 times (for CELLS=8, lfsr[7:0]). gen_count = 0.
  2. Otherwise step: row = next(row). gen_count += 1, wrapping modulo 2^GEN_W.
  3. Otherwise hold.
- A seed_load and step in the same cycle: the step is dropped.
- A step held high for N cycles advances N generations.
- Pixel path:
  - line_start=1: pix_cnt = 0. It wins over a simultaneous pix_en.
  - Otherwise pix_en=1: pix_cnt += 1, saturating at CELLS<<PIX_LOG2.
  - Cell index = pix_cnt >> PIX_LOG2.
  - cell_out is registered, one cycle of latency. On a pix_en cycle it takes row[CELLS-1-index], leftmost pixel = MSB cell, using the pre-increment pix_cnt and the row value before that edge's update. Once saturated it is 0.
  - When pix_en=0, cell_out = 0.
  - busy_line = (pix_cnt < CELLS<<PIX_LOG2), registered.
- Row change mid-line: subsequent pixels show the new row; no tearing protection. The top level must issue step only outside active video.
- Reset mid-line: immediate return to reset values regardless of clk.

Test Plan:
- Reset, CELLS=8: release rst_n → row 8'b0001_0000, gen_count=0, cell_out=0; after 1 cycle of the single-line sweep below, cell_out sequence 0,0,0,1,0,0,0,0.
- CELLS=8, PIX_LOG2=0, row 8'b0000_0001, rule 90, bmode 0, one step → row 8'b1000_0010, gen_count=1. Same with bmode 1 → 8'b0000_0010. Same with bmode 2, rule 90 → 8'b1000_0011.
- Rule 30, CELLS=64, centre seed, 4 steps → row matches golden Python model bit-for-bit; gen_count=4.
- seed_load and step asserted together → row = centre seed, gen_count=0. seed_load with seed_rand after 10 enabled cycles from reset → row = LFSR state (golden model) replicated.
- PIX_LOG2=3, CELLS=8: line_start, then 70 pix_en cycles → each cell repeated 8 pixels; pixels 64..69 = 0; busy_line falls after pixel 64. line_start with pix_en in the same cycle → pix_cnt=0.
- ena=0 for 5 cycles with step and pix_en high → row, gen_count, pix_cnt and lfsr unchanged. Assert rst_n low mid-line, between clock edges → outputs reset immediately.
